// File: rtl/adc_spi_rx_pkg.sv
// Shared definitions for the serial ADC receive front end: default geometry
// and the frame sequencer state encoding.
package adc_spi_rx_pkg;

    localparam int unsigned DefDwidth = 10;
    localparam int unsigned DefLead   = 2;
    localparam int unsigned DefClkdiv = 4;
    localparam int unsigned DefPwidth = 16;

    // Encodings are fixed so other stages and debug views agree on them
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StShift = 3'd2,
        StHold  = 3'd3,
        StQuiet = 3'd4
    } adc_state_e;

endpackage

// File: rtl/adc_spi_rx_sample_tick_gen.sv
// Periodic tick generator: one registered tick every sample_period+1 clk
// cycles while enabled. Shared by the periodic stages of the acquisition chain.
module sample_tick_gen #(
    parameter int unsigned PWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [PWIDTH-1:0] sample_period,
    output logic              tick
);

    logic [PWIDTH-1:0] cnt_q;
    logic              tick_q;
    logic              wrap;

    // >= rather than == so a lowered period takes effect immediately
    assign wrap = (cnt_q >= sample_period);

    // Period counter and registered tick; held in reset while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (!enable) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap;
            cnt_q  <= wrap ? '0 : cnt_q + PWIDTH'(1);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/adc_spi_rx.sv
// SPI master for a serial ADC. Each accepted tick runs one frame:
// cs_n low, CLKDIV setup cycles, LEAD+DWIDTH SCLK periods, CLKDIV hold cycles,
// then cs_n high with a fresh sample and CLKDIV quiet cycles.
module adc_spi_rx
    import adc_spi_rx_pkg::*;
#(
    parameter int unsigned DWIDTH = DefDwidth,
    parameter int unsigned LEAD   = DefLead,
    parameter int unsigned CLKDIV = DefClkdiv,
    parameter int unsigned PWIDTH = DefPwidth
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [PWIDTH-1:0] sample_period,
    input  logic              adc_miso,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DWIDTH-1:0] data_out,
    output logic              sample_out,
    output logic              overrun
);

    localparam int unsigned NBITS   = LEAD + DWIDTH;
    localparam int unsigned BitCntW = $clog2(NBITS + 1);
    localparam int unsigned DivCntW = $clog2(CLKDIV);

    localparam logic [DivCntW-1:0] DivLast = DivCntW'(CLKDIV - 1);
    localparam logic [BitCntW-1:0] BitLast = BitCntW'(NBITS - 1);

    logic               tick;
    adc_state_e         state_q;
    logic [DivCntW-1:0] div_q;
    logic [BitCntW-1:0] bit_q;
    logic [NBITS-1:0]   shreg_q;
    logic               cs_n_q;
    logic               sclk_q;
    logic [DWIDTH-1:0]  data_q;
    logic               sample_q;
    logic               overrun_q;
    logic               div_end;

    sample_tick_gen #(
        .PWIDTH (PWIDTH)
    ) u_tick_gen (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sample_period (sample_period),
        .tick          (tick)
    );

    assign div_end = (div_q == DivLast);

    // Frame sequencer with divider, bit counter, shift register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            data_q    <= '0;
            sample_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sample_q  <= 1'b0;
            // A tick outside IDLE is dropped; the running frame is untouched
            overrun_q <= tick && (state_q != StIdle);

            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        state_q <= StSetup;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                    end
                end

                StSetup: begin
                    if (div_end) begin
                        state_q <= StShift;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        div_q <= div_q + DivCntW'(1);
                    end
                end

                StShift: begin
                    if (div_end) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // SCLK is ours, so MISO is stable here without a synchronizer
                            sclk_q  <= 1'b1;
                            shreg_q <= {shreg_q[NBITS-2:0], adc_miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == BitLast) begin
                                state_q <= StHold;
                            end else begin
                                bit_q <= bit_q + BitCntW'(1);
                            end
                        end
                    end else begin
                        div_q <= div_q + DivCntW'(1);
                    end
                end

                StHold: begin
                    if (div_end) begin
                        state_q  <= StQuiet;
                        div_q    <= '0;
                        cs_n_q   <= 1'b1;
                        data_q   <= shreg_q[DWIDTH-1:0];
                        sample_q <= 1'b1;
                    end else begin
                        div_q <= div_q + DivCntW'(1);
                    end
                end

                StQuiet: begin
                    if (div_end) begin
                        state_q <= StIdle;
                        div_q   <= '0;
                    end else begin
                        div_q <= div_q + DivCntW'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    div_q   <= '0;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    // Leading null/start bits are shifted in but never presented
    if (LEAD > 0) begin : g_lead
        logic unused_lead;
        assign unused_lead = ^shreg_q[NBITS-1:DWIDTH];
    end

    assign adc_cs_n   = cs_n_q;
    assign adc_sclk   = sclk_q;
    assign data_out   = data_q;
    assign sample_out = sample_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_spi_rx.sv
// Directed bench for adc_spi_rx with a behavioural serial ADC model.
module tb_adc_spi_rx;

    localparam int unsigned DWIDTH = 10;
    localparam int unsigned LEAD   = 2;
    localparam int unsigned CLKDIV = 4;
    localparam int unsigned PWIDTH = 16;
    localparam int          NBITS  = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [PWIDTH-1:0] sample_period = 16'd199;
    logic              adc_miso = 1'b0;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic [DWIDTH-1:0] data_out;
    logic              sample_out;
    logic              overrun;

    adc_spi_rx #(
        .DWIDTH (DWIDTH),
        .LEAD   (LEAD),
        .CLKDIV (CLKDIV),
        .PWIDTH (PWIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sample_period (sample_period),
        .adc_miso      (adc_miso),
        .adc_cs_n      (adc_cs_n),
        .adc_sclk      (adc_sclk),
        .data_out      (data_out),
        .sample_out    (sample_out),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: first bit valid at cs_n fall, next bit after every sclk fall
    logic [9:0]  model_val  = 10'h000;
    logic [1:0]  model_lead = 2'b00;
    logic [11:0] model_frame = 12'h000;
    int          model_idx  = 0;

    always @(negedge adc_cs_n) begin
        model_frame = {model_lead, model_val};
        model_idx   = 0;
        adc_miso    = model_frame[11];
    end

    always @(negedge adc_sclk) begin
        if (!adc_cs_n) begin
            model_idx++;
            if (model_idx < NBITS) adc_miso = model_frame[11 - model_idx];
        end
    end

    // Bus monitor, sampled on the falling clk edge
    int          cyc = 0;
    int          fall_cnt = 0, last_fall = 0, last_period = 0;
    int          low_start = 0, low_len = 0, rise_cnt = 0;
    int          samp_cnt = 0, samp_rises = 0, samp_lowlen = 0, samp_double = 0;
    int          ovr_cnt = 0;
    logic        samp_cs = 1'b0;
    logic [9:0]  samp_data = '0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b0, samp_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!adc_cs_n && cs_prev) begin
            if (fall_cnt > 0) last_period = cyc - last_fall;
            last_fall = cyc;
            fall_cnt++;
            low_start = cyc;
            rise_cnt  = 0;
        end
        if (adc_cs_n && !cs_prev) low_len = cyc - low_start;
        if (adc_sclk && !sclk_prev) rise_cnt++;
        if (overrun) ovr_cnt++;
        if (sample_out) begin
            samp_cnt++;
            samp_data   = data_out;
            samp_cs     = adc_cs_n;
            samp_rises  = rise_cnt;
            samp_lowlen = low_len;
            if (samp_prev) samp_double++;
        end
        cs_prev   = adc_cs_n;
        sclk_prev = adc_sclk;
        samp_prev = sample_out;
    end

    task automatic wait_sample(input string tag, input int budget);
        int  start;
        bit  seen;
        start = samp_cnt;
        seen  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (samp_cnt != start) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_fall(input string tag, input int budget);
        int  start;
        bit  seen;
        start = fall_cnt;
        seen  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (fall_cnt != start) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rise(input string tag, input int k, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (!adc_cs_n && rise_cnt == k) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [9:0] exp);
        check({tag, "_data"}, 32'(samp_data), 32'(exp));
        check({tag, "_rises"}, 32'(samp_rises), 32'd12);
        check({tag, "_cs_low"}, 32'(samp_lowlen), 32'd104);
        check({tag, "_cs_at_sample"}, 32'(samp_cs), 32'd1);
    endtask

    logic [9:0] t2_vals [4] = '{10'h000, 10'h3FF, 10'h001, 10'h200};

    initial begin
        int ovr0, fc0, n, s0;
        bit hit;

        // Reset state
        #12;
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: basic frame and period
        model_val = 10'h2A5;
        enable    = 1'b1;
        wait_sample("t1", 400);
        check_frame("t1", 10'h2A5);
        model_val = t2_vals[0];
        wait_fall("t1_fall", 300);
        check("t1_period", 32'(last_period), 32'd200);

        // 2: back-to-back patterns
        for (int i = 0; i < 4; i++) begin
            wait_sample("t2", 400);
            check_frame($sformatf("t2_%0d", i), t2_vals[i]);
            if (i < 3) model_val = t2_vals[i + 1];
        end
        check("t2_no_overrun", 32'(ovr_cnt), 32'd0);

        // 3: lead bits set to 1 are discarded
        model_lead = 2'b11;
        model_val  = 10'h155;
        wait_sample("t3", 400);
        check_frame("t3", 10'h155);
        model_lead = 2'b00;

        // 4: period too short, ticks dropped with overrun
        model_val     = 10'h0F0;
        sample_period = 16'd50;
        wait_sample("t4a", 400);
        check("t4a_data", 32'(samp_data), 32'h0F0);
        wait_sample("t4b", 400);
        check_frame("t4b", 10'h0F0);
        ovr0 = ovr_cnt;
        wait_sample("t4c", 400);
        check_frame("t4c", 10'h0F0);
        check("t4_overruns", 32'(ovr_cnt - ovr0), 32'd2);
        check("t4_period", 32'(last_period), 32'd153);

        // 5: disable mid-frame, frame completes, then silence, then re-enable
        model_val     = 10'h1E7;
        sample_period = 16'd199;
        wait_rise("t5_rise", 5, 400);
        #1 enable = 1'b0;
        wait_sample("t5", 400);
        check_frame("t5", 10'h1E7);
        fc0 = fall_cnt;
        repeat (1000) @(posedge clk);
        check("t5_quiet_frames", 32'(fall_cnt), 32'(fc0));
        check("t5_quiet_cs_n", 32'(adc_cs_n), 32'd1);
        model_val = 10'h3C3;
        #1 enable = 1'b1;
        n   = 0;
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (!adc_cs_n) hit = 1;
        end
        check("t5_reenable_latency", 32'(n), 32'd201);

        // 6: asynchronous reset in the middle of SHIFT
        wait_rise("t6_rise", 3, 400);
        s0 = samp_cnt;
        #3 reset = 1'b0;
        #1;
        check("t6_cs_n", 32'(adc_cs_n), 32'd1);
        check("t6_sclk", 32'(adc_sclk), 32'd0);
        check("t6_data", 32'(data_out), 32'd0);
        check("t6_sample", 32'(sample_out), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        check("t6_no_sample", 32'(samp_cnt), 32'(s0));
        wait_sample("t6", 400);
        check_frame("t6", 10'h3C3);

        check("sample_width", 32'(samp_double), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule
